// File: rtl/lsu_mem_if.sv
// Bus bundle between the core control FSM, the load/store unit and the data memory.
// The slave side is the LSU; the master side is whoever drives requests and models memory.
interface lsu_mem_if #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32
);
    localparam int NB = XLEN / 8;
    localparam int LB = $clog2(NB);

    // core request side
    logic                 i_start;
    logic                 i_is_store;
    logic [2:0]           i_funct3;
    logic [XLEN-1:0]      i_base;
    logic [11:0]          i_offset;
    logic [XLEN-1:0]      i_wdata;
    logic                 o_busy;
    logic                 o_done;
    logic                 o_err;
    logic [XLEN-1:0]      o_rdata;

    // memory side
    logic [ADDR_W-LB-1:0] o_realaddr;
    logic [XLEN-1:0]      o_dout;
    logic [NB-1:0]        o_be;
    logic                 o_w;
    logic [XLEN-1:0]      i_din;

    modport slave (
        input  i_start, i_is_store, i_funct3, i_base, i_offset, i_wdata, i_din,
        output o_busy, o_done, o_err, o_rdata, o_realaddr, o_dout, o_be, o_w
    );

    modport master (
        output i_start, i_is_store, i_funct3, i_base, i_offset, i_wdata, i_din,
        input  o_busy, o_done, o_err, o_rdata, o_realaddr, o_dout, o_be, o_w
    );
endinterface

// File: rtl/lsu_mem.sv
// Load/store unit: one byte/half/word/double access per start pulse, with alignment
// and legality checking, programmable memory read latency and sign/zero extension.
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   S_IDLE   | waiting for start; request checked and address/lanes latched
//   S_ACCESS | address, be and dout on the bus; store pulses W here
//   S_WAIT   | load latency countdown; din captured when counter reads 1
//   S_DONE   | done pulse, err=0
//   S_ERR    | done pulse, err=1, no memory access was made
module lsu_mem #(
    parameter int XLEN    = 32,
    parameter int ADDR_W  = 32,
    parameter int MEM_LAT = 1
) (
    input  logic      clk,
    input  logic      resetn,
    lsu_mem_if.slave  bus
);
    localparam int NB = XLEN / 8;
    localparam int LB = $clog2(NB);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ACCESS = 3'd1,
        S_WAIT   = 3'd2,
        S_DONE   = 3'd3,
        S_ERR    = 3'd4
    } state_t;

    state_t               r_state;
    state_t               w_next;

    logic                 r_is_store;
    logic [2:0]           r_funct3;
    logic [LB-1:0]        r_lane;
    logic [3:0]           r_cnt;
    logic [XLEN-1:0]      r_rdata;
    logic [XLEN-1:0]      r_dout;
    logic [ADDR_W-LB-1:0] r_realaddr;
    logic [NB-1:0]        r_be;

    logic [ADDR_W-1:0]    w_eff;
    logic [1:0]           w_sz;
    logic                 w_illegal;
    logic                 w_misalign;
    logic                 w_bad;
    logic [XLEN-1:0]      w_st_data;
    logic [NB-1:0]        w_be_mask;
    logic [NB-1:0]        w_be_st;
    logic [XLEN-1:0]      w_shift;
    logic [6:0]           w_nbits;
    logic [XLEN-1:0]      w_mask;
    logic                 w_top;
    logic                 w_sign;
    logic [XLEN-1:0]      w_ext;

    // Effective address wraps modulo 2^ADDR_W; the carry is simply dropped.
    assign w_eff = bus.i_base[ADDR_W-1:0] + {{(ADDR_W-12){bus.i_offset[11]}}, bus.i_offset};
    assign w_sz  = bus.i_funct3[1:0];

    // Request legality and natural alignment of the incoming request
    always_comb begin
        w_illegal = (bus.i_funct3 == 3'b111)
                 || ((XLEN == 32) && ((bus.i_funct3 == 3'b011) || (bus.i_funct3 == 3'b110)))
                 || (bus.i_is_store && bus.i_funct3[2]);
        w_misalign = ((w_sz == 2'd1) && w_eff[0])
                  || ((w_sz == 2'd2) && (w_eff[1:0] != 2'b00))
                  || ((w_sz == 2'd3) && (w_eff[2:0] != 3'b000));
        w_bad = w_illegal || w_misalign;
    end

    // Store data replicated across lanes so the memory only has to honour be
    always_comb begin
        w_st_data = bus.i_wdata;
        case (w_sz)
            2'd0:    w_st_data = {NB{bus.i_wdata[7:0]}};
            2'd1:    w_st_data = {(NB/2){bus.i_wdata[15:0]}};
            2'd2:    w_st_data = {(NB/4){bus.i_wdata[31:0]}};
            default: w_st_data = bus.i_wdata;
        endcase
    end

    // Store byte enables: size-many ones placed at the addressed lane
    assign w_be_mask = ~({NB{1'b1}} << (4'd1 << w_sz));
    assign w_be_st   = w_be_mask << w_eff[LB-1:0];

    // Load lane select and sign/zero extension of the captured memory word
    always_comb begin
        w_shift = bus.i_din >> {r_lane, 3'b000};
        w_nbits = 7'd8 << r_funct3[1:0];
        w_mask  = ~({XLEN{1'b1}} << w_nbits);
        case (r_funct3[1:0])
            2'd0:    w_top = w_shift[7];
            2'd1:    w_top = w_shift[15];
            2'd2:    w_top = w_shift[31];
            default: w_top = w_shift[XLEN-1];
        endcase
        w_sign = w_top & ~r_funct3[2];
        w_ext  = (w_shift & w_mask) | ({XLEN{w_sign}} & ~w_mask);
    end

    // State register
    always_ff @(posedge clk) begin
        if (!resetn) r_state <= S_IDLE;
        else         r_state <= w_next;
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (bus.i_start) w_next = w_bad ? S_ERR : S_ACCESS;
            S_ACCESS: w_next = r_is_store ? S_DONE : S_WAIT;
            S_WAIT:   if (r_cnt == 4'd1) w_next = S_DONE;
            S_DONE:   w_next = S_IDLE;
            S_ERR:    w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // Status and write-strobe outputs decoded from the current state
    always_comb begin
        bus.o_busy = (r_state == S_ACCESS) || (r_state == S_WAIT) || (r_state == S_DONE);
        bus.o_done = (r_state == S_DONE) || (r_state == S_ERR);
        bus.o_err  = (r_state == S_ERR);
        bus.o_w    = (r_state == S_ACCESS) && r_is_store;
    end

    // Request latch, latency counter and load result capture.
    // be is dropped after DONE so an error response never shows stale enables.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_is_store <= 1'b0;
            r_funct3   <= 3'b000;
            r_lane     <= '0;
            r_cnt      <= 4'd0;
            r_rdata    <= '0;
            r_dout     <= '0;
            r_realaddr <= '0;
            r_be       <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.i_start && !w_bad) begin
                        r_is_store <= bus.i_is_store;
                        r_funct3   <= bus.i_funct3;
                        r_lane     <= w_eff[LB-1:0];
                        r_realaddr <= w_eff[ADDR_W-1:LB];
                        r_dout     <= w_st_data;
                        r_be       <= bus.i_is_store ? w_be_st : {NB{1'b1}};
                    end
                end
                S_ACCESS: r_cnt <= 4'(MEM_LAT);
                S_WAIT: begin
                    if (r_cnt == 4'd1) r_rdata <= w_ext;
                    else               r_cnt   <= r_cnt - 4'd1;
                end
                S_DONE:  r_be <= '0;
                default: ;
            endcase
        end
    end

    assign bus.o_rdata    = r_rdata;
    assign bus.o_realaddr = r_realaddr;
    assign bus.o_dout     = r_dout;
    assign bus.o_be       = r_be;

endmodule

// File: tb/tb_lsu_mem.sv
// Bench for lsu_mem: a 32-bit/latency-2 instance and a 64-bit/latency-1 instance,
// directed cases plus random requests checked against an arithmetic reference model.
module tb_lsu_mem;
    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    lsu_mem_if #(.XLEN(32), .ADDR_W(32)) if32();
    lsu_mem_if #(.XLEN(64), .ADDR_W(32)) if64();

    lsu_mem #(.XLEN(32), .ADDR_W(32), .MEM_LAT(2)) dut32 (
        .clk(clk), .resetn(resetn), .bus(if32.slave));
    lsu_mem #(.XLEN(64), .ADDR_W(32), .MEM_LAT(1)) dut64 (
        .clk(clk), .resetn(resetn), .bus(if64.slave));

    // shared stimulus; sel picks which instance receives start and is observed
    bit          sel;
    logic        t_start;
    logic        t_is_store;
    logic [2:0]  t_f3;
    logic [63:0] t_base;
    logic [11:0] t_off;
    logic [63:0] t_wdata;
    logic [63:0] t_din;

    assign if32.i_start    = t_start & ~sel;
    assign if32.i_is_store = t_is_store;
    assign if32.i_funct3   = t_f3;
    assign if32.i_base     = t_base[31:0];
    assign if32.i_offset   = t_off;
    assign if32.i_wdata    = t_wdata[31:0];
    assign if32.i_din      = t_din[31:0];
    assign if64.i_start    = t_start & sel;
    assign if64.i_is_store = t_is_store;
    assign if64.i_funct3   = t_f3;
    assign if64.i_base     = t_base;
    assign if64.i_offset   = t_off;
    assign if64.i_wdata    = t_wdata;
    assign if64.i_din      = t_din;

    logic        m_busy, m_done, m_err, m_w;
    logic [63:0] m_rdata, m_dout, m_addr;
    logic [7:0]  m_be;

    always_comb begin
        if (sel) begin
            m_busy  = if64.o_busy;
            m_done  = if64.o_done;
            m_err   = if64.o_err;
            m_w     = if64.o_w;
            m_rdata = if64.o_rdata;
            m_dout  = if64.o_dout;
            m_addr  = 64'(if64.o_realaddr);
            m_be    = if64.o_be;
        end else begin
            m_busy  = if32.o_busy;
            m_done  = if32.o_done;
            m_err   = if32.o_err;
            m_w     = if32.o_w;
            m_rdata = 64'(if32.o_rdata);
            m_dout  = 64'(if32.o_dout);
            m_addr  = 64'(if32.o_realaddr);
            m_be    = 8'(if32.o_be);
        end
    end

    int n_chk = 0;
    int n_err = 0;
    logic [63:0] prev_rdata [2];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (xlen=%0d)", tag, obs, exp, sel ? 64 : 32);
        end
    endtask

    // One request on the selected instance, checked cycle by cycle against the model.
    task automatic txn(input bit st, input bit [2:0] f3, input bit [63:0] base,
                       input bit [11:0] off, input bit [63:0] wd, input bit [63:0] din_v,
                       input bit spam);
        int          xlen, lat, nb, lb, size, lane, exp_done, wcnt;
        bit          illegal, mis, exp_err, got_done;
        logic [31:0] eff;
        logic [63:0] exp_be, exp_dout, exp_rd, msk, v;
        xlen = sel ? 64 : 32;
        lat  = sel ? 1 : 2;
        nb   = xlen / 8;
        lb   = sel ? 3 : 2;
        eff  = base[31:0] + {{20{off[11]}}, off};
        size = 1 << f3[1:0];
        illegal = (f3 == 3'd7) || (!sel && (f3 == 3'd3 || f3 == 3'd6)) || (st && f3[2]);
        mis     = (eff % size) != 0;
        exp_err = illegal || mis;
        lane    = int'(eff % nb);
        exp_be  = st ? (((64'd1 << size) - 1) << lane) : ((64'd1 << nb) - 1);
        exp_dout = 64'd0;
        for (int i = 0; i < nb; i++)
            exp_dout = exp_dout | (((wd >> (8 * (i % size))) & 64'hFF) << (8 * i));
        v = din_v >> (8 * lane);
        if (size < 8) begin
            msk = (64'd1 << (size * 8)) - 1;
            v   = v & msk;
            if (!f3[2] && v[size*8-1]) v = v | ~msk;
        end
        if (xlen == 32) v = v & 64'hFFFF_FFFF;
        exp_rd   = v;
        exp_done = exp_err ? 1 : (st ? 2 : 2 + lat);

        @(negedge clk);
        t_is_store = st;
        t_f3       = f3;
        t_base     = base;
        t_off      = off;
        t_wdata    = wd;
        t_din      = {$urandom, $urandom};
        t_start    = 1'b1;
        @(posedge clk);
        got_done = 0;
        wcnt     = 0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (!spam && c == 1) t_start = 1'b0;
            t_din = (c == 1 + lat) ? din_v : {$urandom, $urandom};
            chk("busy", 64'(m_busy), 64'(!exp_err && c <= exp_done));
            if (m_w) wcnt++;
            if (c == 1) begin
                if (exp_err) begin
                    chk("err_be", 64'(m_be), 64'd0);
                    chk("err_w", 64'(m_w), 64'd0);
                end else begin
                    chk("realaddr", m_addr, 64'(eff >> lb));
                    chk("be", 64'(m_be), exp_be);
                    if (st) chk("dout", m_dout, exp_dout);
                end
            end
            if (m_done) begin
                chk("done_cycle", 64'(c), 64'(exp_done));
                chk("err", 64'(m_err), 64'(exp_err));
                if (!exp_err && !st) prev_rdata[sel] = exp_rd;
                chk("rdata", m_rdata, prev_rdata[sel]);
                t_start  = 1'b0;
                got_done = 1;
                break;
            end
        end
        t_start = 1'b0;
        if (!got_done) chk("done_timeout", 64'd0, 64'd1);
        chk("w_pulses", 64'(wcnt), 64'(st && !exp_err));
        @(negedge clk);
        chk("extra_done", 64'(m_done), 64'd0);
    endtask

    initial begin
        resetn     = 1'b0;
        sel        = 1'b0;
        t_start    = 1'b0;
        t_is_store = 1'b0;
        t_f3       = 3'd0;
        t_base     = 64'd0;
        t_off      = 12'd0;
        t_wdata    = 64'd0;
        t_din      = 64'd0;
        prev_rdata[0] = 64'd0;
        prev_rdata[1] = 64'd0;
        repeat (3) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            sel = bit'(s);
            #1;
            chk("rst_busy", 64'(m_busy), 64'd0);
            chk("rst_done", 64'(m_done), 64'd0);
            chk("rst_err", 64'(m_err), 64'd0);
            chk("rst_w", 64'(m_w), 64'd0);
            chk("rst_rdata", m_rdata, 64'd0);
            chk("rst_addr", m_addr, 64'd0);
            chk("rst_dout", m_dout, 64'd0);
            chk("rst_be", 64'(m_be), 64'd0);
        end
        sel = 1'b0;
        resetn = 1'b1;

        // 32-bit instance, directed
        txn(1, 3'b010, 64'h100, 12'd4, 64'hDEADBEEF, 64'd0, 0);
        txn(0, 3'b000, 64'h103, 12'd0, 64'd0, 64'h80FF1234, 0);
        txn(0, 3'b100, 64'h103, 12'd0, 64'd0, 64'h80FF1234, 0);
        txn(0, 3'b001, 64'h102, 12'd0, 64'd0, 64'h80FF1234, 0);
        txn(1, 3'b001, 64'h102, 12'd0, 64'h0000ABCD, 64'd0, 0);
        txn(1, 3'b000, 64'h101, 12'd0, 64'h5A, 64'd0, 0);
        txn(0, 3'b010, 64'h101, 12'd0, 64'd0, 64'h12345678, 0);
        txn(0, 3'b011, 64'h100, 12'd0, 64'd0, 64'h12345678, 0);
        txn(1, 3'b100, 64'h100, 12'd0, 64'h77, 64'd0, 0);
        txn(0, 3'b010, 64'h10, 12'hFFC, 64'd0, 64'hCAFEF00D, 0);
        txn(0, 3'b010, 64'h0, 12'hFFC, 64'd0, 64'h0BADC0DE, 0);
        txn(0, 3'b000, 64'h200, 12'd1, 64'd0, 64'h0000F100, 1);
        txn(1, 3'b000, 64'h200, 12'd2, 64'h99, 64'd0, 1);

        // reset while the 32-bit instance sits in WAIT
        @(negedge clk);
        t_is_store = 1'b0;
        t_f3       = 3'b010;
        t_base     = 64'h100;
        t_off      = 12'd0;
        t_start    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        t_start = 1'b0;
        @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        chk("abort_busy", 64'(m_busy), 64'd0);
        chk("abort_w", 64'(m_w), 64'd0);
        chk("abort_rdata", m_rdata, 64'd0);
        chk("abort_done", 64'(m_done), 64'd0);
        resetn = 1'b1;
        prev_rdata[0] = 64'd0;
        prev_rdata[1] = 64'd0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("abort_no_done", 64'(m_done), 64'd0);
        end

        // 64-bit instance, directed
        sel = 1'b1;
        txn(1, 3'b011, 64'h100, 12'd0, 64'h0123456789ABCDEF, 64'd0, 0);
        txn(0, 3'b011, 64'h108, 12'd0, 64'd0, 64'hFEDCBA9876543210, 0);
        txn(0, 3'b110, 64'h100, 12'd0, 64'd0, 64'h00000000FFFFFFFF, 0);
        txn(0, 3'b010, 64'h104, 12'd0, 64'd0, 64'h80000000_00000000, 0);
        txn(1, 3'b001, 64'h106, 12'd0, 64'h1234, 64'd0, 0);
        txn(0, 3'b011, 64'h104, 12'd0, 64'd0, 64'h1, 0);

        // random requests on both instances
        for (int s = 0; s < 2; s++) begin
            sel = bit'(s);
            for (int k = 0; k < 40; k++) begin
                bit [63:0] rb;
                bit [11:0] ro;
                rb = {$urandom, $urandom};
                ro = 12'($urandom);
                if ($urandom_range(1, 0) == 1) rb[2:0] = 3'b000;
                if ($urandom_range(1, 0) == 1) ro[2:0] = 3'b000;
                txn(bit'($urandom_range(1, 0)), 3'($urandom_range(7, 0)), rb, ro,
                    {$urandom, $urandom}, {$urandom, $urandom}, $urandom_range(3, 0) == 0);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/lsu_mem.md
# lsu_mem

Parametrised load/store unit between the multicycle core control FSM and the synchronous data memory. It takes one load or store request per start pulse and computes the effective address as base + sign-extended 12-bit offset. It checks alignment, drives memory address, write data, byte enables and W, waits a configurable memory latency, then returns a sign- or zero-extended result with a one-cycle done pulse. It replaces the fixed word-only, fixed-wait load/store path of the current core with byte, halfword, word and (at XLEN=64) doubleword access and a misalignment error.

## Interface
- XLEN, 32: datapath width; legal values 32 or 64; byte lanes NB = XLEN/8, lane-select bits LB = log2(NB).
- ADDR_W, 32: byte-address width; effective-address arithmetic is modulo 2^ADDR_W.
- MEM_LAT, 1: cycles from realaddr presented until din is valid; legal values 1 to 15.

- clk  in  1  clock; all state changes on rising edge.
- resetn  in  1  synchronous, active-low reset.
- start  in  1  request strobe; sampled only in IDLE.
- is_store  in  1  1 = store, 0 = load.
- funct3  in  3  RISC-V width/sign code: 000 B, 001 H, 010 W, 011 D, 100 BU, 101 HU, 110 WU.
- base  in  XLEN  base register value; low ADDR_W bits used.
- offset  in  12  signed immediate.
- wdata  in  XLEN  store data, right-justified.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle completion pulse.
- err  out  1  valid with done; 1 = illegal or misaligned request, no memory access made.
- rdata  out  XLEN  load result; held until the next successful load completes.
- realaddr  out  ADDR_W-LB  memory word address = eff >> LB.
- dout  out  XLEN  memory write data.
- be  out  NB  byte enables.
- W  out  1  memory write strobe.
- din  in  XLEN  memory read data.

## Operation
- States: IDLE, ACCESS, WAIT, DONE, ERR.
- IDLE, start=1 computes eff = base + sext(offset), with the carry out of ADDR_W discarded.
- Legality check in IDLE:
  - Illegal if funct3=011 or 110 and XLEN=32.
  - Illegal if funct3 = 111.
  - Illegal if it is a store and funct3[2]=1.
  - Misaligned if the size is H and eff[0]≠0.
  - Misaligned if the size is W and eff[1:0]≠0.
  - Misaligned if the size is D and eff[2:0]≠0.
- Illegal or misaligned requests go to ERR. Otherwise realaddr, be and dout are registered and the FSM goes to ACCESS.
- Store lanes: the byte is replicated to every lane and the half is replicated to every half-lane. be has size-many ones shifted left by eff[LB-1:0].
- Load lanes: be is all ones.
- ACCESS (1 cycle):
  - A store asserts W for exactly this cycle, then goes to DONE.
  - A load loads the wait counter with MEM_LAT and goes to WAIT.
- WAIT: the counter decrements each cycle. On the cycle the counter equals 1, din is captured and the FSM goes to DONE.
- Load extraction: the lane at eff[LB-1:0] is selected. It is sign-extended when funct3[2]=0 and zero-extended when funct3[2]=1. The result is written to rdata at the same edge the FSM enters DONE.
- DONE: done=1, err=0, then IDLE.
- ERR: done=1, err=1, then IDLE. rdata is unchanged and W stays 0.
- realaddr, dout and be hold their values from ACCESS through DONE.
- start is ignored whenever the FSM is not in IDLE.

## Timing
- Cycle 0 is the cycle start is sampled in IDLE.
- Store: realaddr, dout, be and W are valid in cycle 1; done in cycle 2.
- Load: realaddr is valid from cycle 1; din is sampled at the end of cycle 1+MEM_LAT; done and rdata are valid in cycle 2+MEM_LAT.
- Error: done=err=1 in cycle 1; busy is never asserted.
- busy is high from cycle 1 to the done cycle inclusive (error case excepted).
- Back-to-back requests: a new start is accepted in the cycle after done.
- Reset values of all outputs are 0: busy, done, err, rdata, realaddr, dout, be, W. The FSM resets to IDLE.
- resetn low in any state (mid-operation included) forces IDLE at the next edge:
  - W and done are 0 from that edge.
  - No done is ever produced for the aborted request.
  - rdata clears to 0.

## Test plan
- XLEN=32, MEM_LAT=2. SW base=0x100, offset=4, wdata=0xDEADBEEF -> cycle 1: realaddr=0x41, be=1111, dout=0xDEADBEEF, W=1 for one cycle only; cycle 2: done=1, err=0.
- Loads with din=0x80FF1234:
  - LB base=0x103 -> rdata=0xFFFFFF80.
  - LBU -> rdata=0x00000080.
  - LH base=0x102 -> rdata=0xFFFF80FF.
  - In each case done is in cycle 4 and no W pulse occurs.
- SH base=0x102, wdata=0x0000ABCD -> dout=0xABCDABCD, be=1100. SB base=0x101, wdata=0x5A -> dout=0x5A5A5A5A, be=0010.
- Error cases:
  - LW base=0x101 -> cycle 1: done=1, err=1; busy, W and be stay 0; rdata is unchanged.
  - funct3=011 at XLEN=32, and SB with funct3=100 -> same error response.
- Negative offset and wrap:
  - LW base=0x10, offset=0xFFC -> realaddr=0x3.
  - LW base=0, offset=0xFFC -> realaddr=0x3FFFFFFF.
  - start pulsed every cycle while busy -> exactly one done per accepted request.
- Reset and parameter sweep:
  - resetn=0 during WAIT -> next cycle busy=0, W=0, rdata=0, no done.
  - Repeat the load and store scenarios at XLEN=64, MEM_LAT=1: LD/SD, LWU of 0xFFFFFFFF -> 0x00000000FFFFFFFF, done in cycle 3.
